// File: rtl/dvs_ravens_event_tx_pkg.sv
// Shared definitions for the DVS -> Ravens event transmitter.
// Packed event layout: {pol[32], ts[31:16], y[15:8], x[7:0]}.
// A frame carries one event, sent least-significant byte first.
package dvs_ravens_event_tx_pkg;

  localparam int EVENT_W  = 33;
  localparam int X_W      = 8;
  localparam int Y_W      = 8;
  localparam int TS_W     = 16;
  localparam int TX_BYTES = (EVENT_W + 7) / 8;

  localparam int X_LSB    = 0;
  localparam int Y_LSB    = X_LSB + X_W;
  localparam int TS_LSB   = Y_LSB + Y_W;
  localparam int POL_BIT  = TS_LSB + TS_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LOAD = 2'd2,
    SEND = 2'd3
  } tx_state_t;

endpackage

// File: rtl/dvs_ravens_event_tx.sv
// Read master (M2) of the DVS event queue. Requests the arbiter, pops one
// event per grant and streams it to the Ravens input pins as a fixed-length
// byte frame over valid/ready.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   tx_en              1 = keep fetching events; 0 = finish frame, then idle
//   req_m2 / grant_m2  arbiter request / grant
//   fifo_rd_en         pop strobe (grant_m2 gated by REQ state)
//   fifo_rd_data       popped event, valid the cycle after fifo_rd_en
//   tx_data/valid/ready/last  byte stream towards Ravens
//   busy               FSM not idle
//   evt_count          completed frames, free-running modulo 2^16
//
// state | meaning
// IDLE  | nothing in flight, waiting for tx_en
// REQ   | requesting the arbiter; pop happens in the granted cycle
// LOAD  | popped data arrives, captured into the shift register
// SEND  | presenting frame bytes, LSB first, advancing on handshake
module dvs_ravens_event_tx
  import dvs_ravens_event_tx_pkg::*;
#(
  parameter int EVENT_W = dvs_ravens_event_tx_pkg::EVENT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tx_en,
  output logic               req_m2,
  input  logic               grant_m2,
  output logic               fifo_rd_en,
  input  logic [EVENT_W-1:0] fifo_rd_data,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_last,
  output logic               busy,
  output logic [15:0]        evt_count
);

  localparam int TX_BYTES = (EVENT_W + 7) / 8;
  localparam int SHIFT_W  = 8 * TX_BYTES;

  tx_state_t          r_state;
  tx_state_t          w_state_nxt;
  logic [SHIFT_W-1:0] r_shift;
  logic [2:0]         r_idx;
  logic [15:0]        r_evt_count;
  logic               w_hs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_idx       <= '0;
      r_evt_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        LOAD: begin
          // Zero-extend so the top byte carries only the polarity bit.
          r_shift <= SHIFT_W'(fifo_rd_data);
          r_idx   <= '0;
        end
        SEND: begin
          if (w_hs) begin
            r_shift <= r_shift >> 8;
            r_idx   <= r_idx + 3'd1;
            if (tx_last) begin
              r_evt_count <= r_evt_count + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_m2      = 1'b0;
    fifo_rd_en  = 1'b0;
    tx_valid    = 1'b0;
    tx_last     = 1'b0;
    w_hs        = 1'b0;
    case (r_state)
      IDLE: begin
        if (tx_en) w_state_nxt = REQ;
      end
      REQ: begin
        req_m2     = 1'b1;
        fifo_rd_en = grant_m2;
        if (grant_m2)   w_state_nxt = LOAD;
        else if (!tx_en) w_state_nxt = IDLE;
      end
      LOAD: begin
        w_state_nxt = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_last  = (r_idx == 3'(TX_BYTES - 1));
        w_hs     = tx_ready;
        // tx_en is only consulted once the whole frame is out.
        if (w_hs && tx_last) w_state_nxt = tx_en ? REQ : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shift register drains to zero, so tx_data reads 0x00 outside SEND.
  assign tx_data   = r_shift[7:0];
  assign busy      = (r_state != IDLE);
  assign evt_count = r_evt_count;

endmodule

// File: doc/dvs_ravens_event_tx.md
# dvs_ravens_event_tx

Transmit end of the DVS event queue. Acts as the queue's read master (M2): requests the event-queue arbiter, pops one packed DVS event per grant, and streams it to the Ravens side as a fixed-length byte frame over a valid/ready interface. Sits between the event FIFO read port and the Ravens parallel input pins.

## Interface
Parameters:
- EVENT_W, 33, packed event width {pol[32], ts[31:16], y[15:8], x[7:0]}
- TX_BYTES, ceil(EVENT_W/8) = 5, bytes per frame (derived; not overridden independently)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- tx_en  in  1  enable; 0 = finish current frame, then idle
- req_m2  out  1  read request to arbiter M2 port
- grant_m2  in  1  arbiter grant (already gated by FIFO not-empty and M1 priority)
- fifo_rd_en  out  1  FIFO pop strobe
- fifo_rd_data  in  EVENT_W  FIFO read data, valid the cycle after fifo_rd_en
- tx_data  out  8  frame byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  Ravens accepts byte
- tx_last  out  1  marks final byte of frame
- busy  out  1  state != IDLE
- evt_count  out  16  completed frames, wraps 0xFFFF -> 0x0000

## Operation
- FSM states: IDLE, REQ, LOAD, SEND.
- IDLE: all handshake outputs 0. tx_en=1 -> REQ.
- REQ: req_m2=1. fifo_rd_en = grant_m2 (combinational, only in REQ). grant_m2=1 -> LOAD. tx_en=0 while in REQ with no grant -> IDLE (no pop).
- LOAD: capture fifo_rd_data into shift register zero-extended to 8*TX_BYTES bits; byte index := 0 -> SEND.
- SEND: tx_valid=1, tx_data = shift_reg[7:0]; tx_last=1 when byte index = TX_BYTES-1. On tx_valid&tx_ready: shift right 8, index+1. Handshake on last byte: evt_count+1, next state REQ if tx_en else IDLE.
- Byte order LSB first: x, y, ts[7:0], ts[15:8], {7'b0, pol}.
- tx_en has no effect inside LOAD/SEND; a frame once popped is always sent whole.
- tx_data, tx_last held stable while tx_valid=1 and tx_ready=0.
- tx_ready ignored when tx_valid=0.
- FIFO empty / M1 priority: handled by arbiter withholding grant; block holds req_m2 in REQ indefinitely, no timeout.

## Timing
- Reset (rst_n=0 at a clk edge): state IDLE, req_m2=0, fifo_rd_en=0, tx_valid=0, tx_data=0x00, tx_last=0, busy=0, evt_count=0, shift register 0.
- Reset mid-frame: partial frame discarded, popped event lost; no further bytes after reset edge.
- Grant in cycle N: pop in N; LOAD in N+1; tx_valid=1 with byte 0 in N+2.
- tx_ready held 1: bytes in N+2..N+6; evt_count updates in N+7; req_m2=1 again in N+7.
- Minimum 7 cycles per event with tx_ready=1 and continuous grant.
- req_m2, tx_valid, tx_last, busy are registered-state decodes; fifo_rd_en is the only output combinationally dependent on an input (grant_m2).
- evt_count 16-bit unsigned, modulo 2^16.

## Structure
- Shared package: EVENT_W, X_W=8, Y_W=8, TS_W=16, TX_BYTES, field offset constants, typedef enum logic [1:0] tx_state_t {IDLE, REQ, LOAD, SEND}.
- Single module; FSM + shift register + 3-bit byte index + counter. No sub-module.

## Test plan
- Reset: rst_n=0 for 2 cycles mid-SEND (byte 2) -> all outputs 0 next cycle, evt_count=0, no further tx_valid.
- Single event: FIFO holds 0x1_ABCD_3412, grant at N, tx_ready=1 -> bytes 0x12,0x34,0xCD,0xAB,0x01 in N+2..N+6, tx_last only at N+6, evt_count=1.
- Backpressure: tx_ready low 3 cycles on byte 1 -> tx_data=0x34 held stable, frame completes 3 cycles later, no duplicate or skipped byte.
- Grant withheld (empty FIFO / M1 priority) for 10 cycles -> req_m2 stays 1, fifo_rd_en=0 throughout, no pop; pop in first granted cycle.
- tx_en dropped during byte 2 -> frame completes all 5 bytes, state returns IDLE, req_m2=0; tx_en=0 in REQ without grant -> IDLE, no pop.
- Counter wrap: preload via 65536 back-to-back events -> evt_count 0xFFFF -> 0x0000, 7-cycle spacing between frames.
